// File: rtl/approx_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_sweep_pkg
//  Description : Shared state encoding and width helpers for the approximate
//                adder error-characterisation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package approx_sweep_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sweep_state_t;

  // Width of the {b,a} vector index
  function automatic int vec_w(input int w);
    return 2 * w;
  endfunction

  // Width of the adder result and of the error magnitude
  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  // Width of the mismatch counter (must hold 2^(2W))
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  // Width of the error accumulator (2^(2W) vectors times a W+1 bit error)
  function automatic int esum_w(input int w);
    return 3 * w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sweep_err_unit.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_err_unit
//  Description : Combinational error magnitude of one approximate-adder result
//                against the exact sum of the operands packed in vec = {b,a}.
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_err_unit
  import approx_sweep_pkg::*;
#(
  parameter int W = 2
) (
  input  logic [2*W-1:0] vec,
  input  logic [W:0]     sum,
  output logic [W:0]     err,
  output logic           err_nz
);

  localparam int EXT_W = W + 2;

  logic [EXT_W-1:0] exact_ext;
  logic [EXT_W-1:0] sum_ext;
  logic [EXT_W-1:0] diff;
  logic [EXT_W-1:0] mag;

  // Signed difference in W+2 bits; the magnitude always fits in W+1 bits
  always_comb begin
    exact_ext = {2'b00, vec[W-1:0]} + {2'b00, vec[2*W-1:W]};
    sum_ext   = {1'b0, sum};
    diff      = sum_ext - exact_ext;
    mag       = diff[EXT_W-1] ? (~diff + 1'b1) : diff;
    err       = mag[W:0];
    err_nz    = (mag != '0);
  end

endmodule
`default_nettype wire

// File: rtl/approx_adder_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : approx_adder_sweep_ctrl
//  Description : Exhaustive sweep of all {b,a} operand pairs through one
//                combinational approximate adder; records max |error|, the
//                first vector reaching it, the mismatch count and pass/fail.
//                Optional macro SWEEP_ERR_SUM_EN adds the err_sum output
//                (sum of |error| over the whole sweep).
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_adder_sweep_ctrl
  import approx_sweep_pkg::*;
#(
  parameter int          W  = 2,
  parameter int unsigned ET = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic [W-1:0]   adder_a,
  output logic [W-1:0]   adder_b,
  input  logic [W:0]     adder_sum,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [W:0]     max_err,
  output logic [2*W-1:0] worst_vec,
  output logic [2*W:0]   err_cnt
`ifdef SWEEP_ERR_SUM_EN
  ,
  output logic [3*W+1:0] err_sum
`endif
);

  localparam int VEC_W  = vec_w(W);
  localparam int SUM_W  = sum_w(W);
  localparam int CNT_W  = cnt_w(W);
  localparam int ESUM_W = esum_w(W);

  sweep_state_t     state_q,     state_d;
  logic [VEC_W-1:0] vec_q,       vec_d;
  logic [VEC_W-1:0] stage_vec_q, stage_vec_d;
  logic [SUM_W-1:0] stage_sum_q, stage_sum_d;
  logic             stage_vld_q, stage_vld_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;
  logic [SUM_W-1:0] max_err_q,   max_err_d;
  logic [VEC_W-1:0] worst_vec_q, worst_vec_d;
  logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
`ifdef SWEEP_ERR_SUM_EN
  logic [ESUM_W-1:0] err_sum_q,  err_sum_d;
`endif

  logic [SUM_W-1:0] stage_err;
  logic             stage_err_nz;

  // Error of the vector issued in the previous cycle
  sweep_err_unit #(
    .W (W)
  ) u_err (
    .vec    (stage_vec_q),
    .sum    (stage_sum_q),
    .err    (stage_err),
    .err_nz (stage_err_nz)
  );

  // Next-state, vector stepping and result accumulation
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    stage_vec_d = vec_q;
    stage_sum_d = adder_sum;
    stage_vld_d = (state_q == S_RUN);
    pass_d      = pass_q;
    max_err_d   = max_err_q;
    worst_vec_d = worst_vec_q;
    err_cnt_d   = err_cnt_q;
    done_d      = 1'b0;
`ifdef SWEEP_ERR_SUM_EN
    err_sum_d   = err_sum_q;
`endif

    // Fold in the staged vector; strict compare keeps the first worst vector
    if (stage_vld_q) begin
      if (stage_err_nz) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (stage_err > max_err_q) begin
        max_err_d   = stage_err;
        worst_vec_d = stage_vec_q;
      end
`ifdef SWEEP_ERR_SUM_EN
      err_sum_d = err_sum_q + ESUM_W'(stage_err);
`endif
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          vec_d       = '0;
          pass_d      = 1'b0;
          max_err_d   = '0;
          worst_vec_d = '0;
          err_cnt_d   = '0;
`ifdef SWEEP_ERR_SUM_EN
          err_sum_d   = '0;
`endif
        end
      end
      S_RUN: begin
        if (vec_q == {VEC_W{1'b1}}) begin
          state_d = S_DRAIN;
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = ({{(32-SUM_W){1'b0}}, max_err_d} <= ET);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous start
    if (abort) begin
      state_d     = S_IDLE;
      vec_d       = '0;
      stage_vld_d = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      max_err_d   = '0;
      worst_vec_d = '0;
      err_cnt_d   = '0;
`ifdef SWEEP_ERR_SUM_EN
      err_sum_d   = '0;
`endif
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      stage_vec_q <= '0;
      stage_sum_q <= '0;
      stage_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      max_err_q   <= '0;
      worst_vec_q <= '0;
      err_cnt_q   <= '0;
`ifdef SWEEP_ERR_SUM_EN
      err_sum_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      stage_vec_q <= stage_vec_d;
      stage_sum_q <= stage_sum_d;
      stage_vld_q <= stage_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      max_err_q   <= max_err_d;
      worst_vec_q <= worst_vec_d;
      err_cnt_q   <= err_cnt_d;
`ifdef SWEEP_ERR_SUM_EN
      err_sum_q   <= err_sum_d;
`endif
    end
  end

  assign adder_a   = vec_q[W-1:0];
  assign adder_b   = vec_q[VEC_W-1:W];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign max_err   = max_err_q;
  assign worst_vec = worst_vec_q;
  assign err_cnt   = err_cnt_q;
`ifdef SWEEP_ERR_SUM_EN
  assign err_sum   = err_sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_approx_adder_sweep_ctrl
//  Description : Randomised self-checking bench for approx_adder_sweep_ctrl.
//                Two instances (ET=7 and ET=3) share control inputs and an
//                approximate adder modelled as a lookup table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_adder_sweep_ctrl;

  localparam int W  = 2;
  localparam int NV = 1 << (2 * W);

  logic clk = 1'b0;
  logic rst, start, abort;

  logic [W-1:0]   a7, b7, a3, b3;
  logic [W:0]     s7, s3;
  logic           busy7, done7, pass7, busy3, done3, pass3;
  logic [W:0]     max7, max3;
  logic [2*W-1:0] wv7, wv3;
  logic [2*W:0]   ec7, ec3;
`ifdef SWEEP_ERR_SUM_EN
  logic [3*W+1:0] es7, es3;
`endif

  logic [W:0] lut [NV];

  int n_vec = 0;
  int n_bad = 0;

  approx_adder_sweep_ctrl #(.W(W), .ET(7)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .adder_a(a7), .adder_b(b7), .adder_sum(s7),
    .busy(busy7), .done(done7), .pass(pass7),
    .max_err(max7), .worst_vec(wv7), .err_cnt(ec7)
`ifdef SWEEP_ERR_SUM_EN
    , .err_sum(es7)
`endif
  );

  approx_adder_sweep_ctrl #(.W(W), .ET(3)) dut_et3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .adder_a(a3), .adder_b(b3), .adder_sum(s3),
    .busy(busy3), .done(done3), .pass(pass3),
    .max_err(max3), .worst_vec(wv3), .err_cnt(ec3)
`ifdef SWEEP_ERR_SUM_EN
    , .err_sum(es3)
`endif
  );

  // Approximate adder: combinational table lookup on the issued operands
  always_comb begin
    s7 = lut[{b7, a7}];
    s3 = lut[{b3, a3}];
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk every operand pair in order using plain integer arithmetic
  task automatic model(output int mx, output int wv, output int cnt, output int esum);
    mx = 0; wv = 0; cnt = 0; esum = 0;
    for (int v = 0; v < NV; v++) begin
      int a, b, e;
      a = v % (1 << W);
      b = v / (1 << W);
      e = int'(lut[v]) - (a + b);
      if (e < 0) e = -e;
      if (e != 0) cnt++;
      if (e > mx) begin mx = e; wv = v; end
      esum += e;
    end
  endtask

  task automatic fill_lut(input int mode);
    for (int v = 0; v < NV; v++) begin
      int a, b, x;
      a = v % (1 << W);
      b = v / (1 << W);
      case (mode)
        0: x = a + b;
        1: x = 0;
        2: x = (1 << (W + 1)) - 1;
        3: x = int'($urandom_range(0, (1 << (W + 1)) - 1));
        default: x = ((a + b) & ~1) | int'($urandom_range(0, 1));
      endcase
      lut[v] = x[W:0];
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy7), 0);
    chk({tag, "_done"}, 32'(done7), 0);
    chk({tag, "_pass"}, 32'(pass7), 0);
    chk({tag, "_max"},  32'(max7),  0);
    chk({tag, "_wv"},   32'(wv7),   0);
    chk({tag, "_cnt"},  32'(ec7),   0);
    chk({tag, "_ab"},   32'({b7, a7}), 0);
`ifdef SWEEP_ERR_SUM_EN
    chk({tag, "_esum"}, 32'(es7), 0);
`endif
  endtask

  // Full sweep from IDLE or DONE; optionally pulse start mid-run
  task automatic run_sweep(input string tag, input bit pulse_mid);
    int mx, wv, cnt, esum;
    int done_at, ndone, ndone3;
    done_at = -1; ndone = 0; ndone3 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      start = (pulse_mid && c == 5);
      tick();
      if (c == 3) chk({tag, "_busy_run"}, 32'(busy7), 1);
      if (done7) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (done3) ndone3++;
    end
    start = 1'b0;
    model(mx, wv, cnt, esum);
    chk({tag, "_done_cycle"}, 32'(done_at), 17);
    chk({tag, "_done_count"}, 32'(ndone), 1);
    chk({tag, "_done3_count"}, 32'(ndone3), 1);
    chk({tag, "_busy_done"}, 32'(busy7), 0);
    chk({tag, "_max"},  32'(max7), 32'(mx));
    chk({tag, "_wv"},   32'(wv7),  32'(wv));
    chk({tag, "_cnt"},  32'(ec7),  32'(cnt));
    chk({tag, "_pass"}, 32'(pass7), 32'(mx <= 7));
    chk({tag, "_pass3"}, 32'(pass3), 32'(mx <= 3));
    chk({tag, "_max3"}, 32'(max3), 32'(mx));
    chk({tag, "_ab_hold"}, 32'({b7, a7}), NV - 1);
`ifdef SWEEP_ERR_SUM_EN
    chk({tag, "_esum"}, 32'(es7), 32'(esum));
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    fill_lut(3);
    tick(); tick();
    rst = 1'b0;
    check_zero("reset");

    // Directed corner tables
    fill_lut(0); run_sweep("exact", 1'b0);
    chk("exact_max_const", 32'(max7), 0);
    fill_lut(1); run_sweep("tied0", 1'b0);
    chk("tied0_wv_const", 32'(wv7), 32'hF);
    chk("tied0_pass3", 32'(pass3), 0);
`ifdef SWEEP_ERR_SUM_EN
    chk("tied0_esum_const", 32'(es7), 48);
`endif
    fill_lut(2); run_sweep("tied7", 1'b0);
    chk("tied7_cnt_const", 32'(ec7), 16);

    // Randomised tables, back-to-back restarts from DONE
    for (int i = 0; i < 6; i++) begin
      fill_lut(3 + (i % 2));
      run_sweep($sformatf("rand%0d", i), (i % 3) == 1);
    end

    // Abort in the middle of a sweep, then watch for a stray done
    fill_lut(1);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check_zero("abort");
    begin
      int nd;
      nd = 0;
      for (int c = 0; c < 25; c++) begin
        tick();
        if (done7) nd++;
      end
      chk("abort_no_done", 32'(nd), 0);
    end
    run_sweep("after_abort", 1'b0);

    // abort and start together from DONE: abort wins
    start = 1'b1; abort = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    check_zero("abort_start");
    tick();
    chk("abort_start_idle", 32'(busy7), 0);

    // Reset mid-sweep
    fill_lut(3);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero("midrst");
    tick(); tick();
    chk("midrst_idle", 32'(busy7), 0);
    run_sweep("after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
